// File: rtl/dac_spi_writer_if.sv
// Register-block update bus in, quad-DAC SPI pins and writer status out.
interface dac_spi_writer_if;
  logic [15:0] dds_gain;
  logic [15:0] cw_gain;
  logic [15:0] dds_current_limit;
  logic [15:0] cw_current_limit;
  logic        dds_gain_update;
  logic        cw_gain_update;
  logic        dds_current_limit_update;
  logic        cw_current_limit_update;
  logic        dac_cs_n;
  logic        dac_sclk;
  logic        dac_mosi;
  logic        busy;
  logic        frame_done;
  logic [3:0]  pending;

  modport master (
    output dds_gain, cw_gain, dds_current_limit, cw_current_limit,
    output dds_gain_update, cw_gain_update, dds_current_limit_update, cw_current_limit_update,
    input  dac_cs_n, dac_sclk, dac_mosi, busy, frame_done, pending
  );

  modport slave (
    input  dds_gain, cw_gain, dds_current_limit, cw_current_limit,
    input  dds_gain_update, cw_gain_update, dds_current_limit_update, cw_current_limit_update,
    output dac_cs_n, dac_sclk, dac_mosi, busy, frame_done, pending
  );
endinterface

// File: rtl/dac_spi_writer.sv
// Captures gain/current-limit updates per channel and writes each latest value
// to the quad setpoint DAC as one 24-bit SPI frame, fixed priority ch0..ch3.
module dac_spi_writer #(
  parameter int         CLK_DIV = 4,
  parameter logic [3:0] DAC_CMD = 4'b0011
) (
  input  logic            clk,
  input  logic            rst,
  dac_spi_writer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  localparam logic [7:0] HRELOAD = 8'(CLK_DIV - 1);

  logic [3:0]  upd;
  logic [15:0] din [4];
  logic [15:0] val [4];
  logic [3:0]  pend;
  logic [1:0]  sel;
  logic        launch;
  logic [23:0] word;

  state_t      state_q, state_d;
  logic [7:0]  hcnt_q, hcnt_d;
  logic [4:0]  bit_q, bit_d;
  logic        half_q, half_d;
  logic [23:0] shreg_q, shreg_d;
  logic        cs_n_q, cs_n_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  assign upd = {bus.cw_current_limit_update, bus.dds_current_limit_update,
                bus.cw_gain_update, bus.dds_gain_update};
  assign din[0] = bus.dds_gain;
  assign din[1] = bus.cw_gain;
  assign din[2] = bus.dds_current_limit;
  assign din[3] = bus.cw_current_limit;

  always_comb begin
    sel = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pend[i]) sel = 2'(i);
    end
  end

  assign launch = (state_q == IDLE) && (|pend);
  assign word   = {DAC_CMD, 2'b00, sel, val[sel]};

  // A strobe coinciding with its own channel's launch wins over the clear,
  // so the new value still gets its own frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
      for (int i = 0; i < 4; i++) val[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (upd[i]) begin
          val[i]  <= din[i];
          pend[i] <= 1'b1;
        end else if (launch && (sel == 2'(i))) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hcnt_q  <= '0;
      bit_q   <= '0;
      half_q  <= 1'b0;
      shreg_q <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      bit_q   <= bit_d;
      half_q  <= half_d;
      shreg_q <= shreg_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    bit_d   = bit_q;
    half_d  = half_q;
    shreg_d = shreg_q;
    cs_n_d  = cs_n_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (launch) begin
          shreg_d = word;
          mosi_d  = word[23];
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          hcnt_d  = HRELOAD;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (hcnt_q != 8'd0) begin
          hcnt_d = hcnt_q - 8'd1;
        end else begin
          hcnt_d  = HRELOAD;
          sclk_d  = 1'b1;
          half_d  = 1'b0;
          bit_d   = 5'd23;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // half_q=0: sclk-high phase of the current bit; half_q=1: low phase.
        if (hcnt_q != 8'd0) begin
          hcnt_d = hcnt_q - 8'd1;
        end else begin
          hcnt_d = HRELOAD;
          if (!half_q) begin
            sclk_d = 1'b0;
            half_d = 1'b1;
            if (bit_q != 5'd0) begin
              shreg_d = {shreg_q[22:0], 1'b0};
              mosi_d  = shreg_q[22];
            end
          end else if (bit_q == 5'd0) begin
            state_d = HOLD;
          end else begin
            sclk_d = 1'b1;
            half_d = 1'b0;
            bit_d  = bit_q - 5'd1;
          end
        end
      end
      HOLD: begin
        if (hcnt_q != 8'd0) begin
          hcnt_d = hcnt_q - 8'd1;
        end else begin
          hcnt_d  = HRELOAD;
          half_d  = 1'b0;
          cs_n_d  = 1'b1;
          mosi_d  = 1'b0;
          done_d  = 1'b1;
          state_d = GAP;
        end
      end
      GAP: begin
        // Two passes of the half-period counter give the 2H inter-frame gap.
        if (hcnt_q != 8'd0) begin
          hcnt_d = hcnt_q - 8'd1;
        end else if (!half_q) begin
          hcnt_d = HRELOAD;
          half_d = 1'b1;
        end else begin
          half_d  = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.dac_cs_n   = cs_n_q;
  assign bus.dac_sclk   = sclk_q;
  assign bus.dac_mosi   = mosi_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;
  assign bus.pending    = pend;

endmodule
